// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction field positions, fetch/decode state
// encoding and the sequential PC step.
package cpu_pkg;

  localparam int INSTR_W  = 32;

  localparam int OP_MSB   = 31;
  localparam int OP_LSB   = 26;
  localparam int FUNC_MSB = 5;
  localparam int FUNC_LSB = 0;
  localparam int RS_MSB   = 25;
  localparam int RS_LSB   = 21;
  localparam int RT_MSB   = 20;
  localparam int RT_LSB   = 16;
  localparam int RD_MSB   = 15;
  localparam int RD_LSB   = 11;
  localparam int IMM_MSB  = 15;
  localparam int IMM_LSB  = 0;
  localparam int IMM_W    = IMM_MSB - IMM_LSB + 1;

  localparam int PC_STEP  = 4;

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_DECODE = 2'd1,
    S_MEM    = 2'd2,
    S_FAULT  = 2'd3
  } state_t;

endpackage

// File: rtl/fetch_decode_unit_if.sv
// Instruction-memory fetch channel: req/addr from the fetch unit, ack/rdata
// from memory.
interface fetch_decode_unit_if #(
  parameter int ADDR_W = 16
) ();
  import cpu_pkg::*;

  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_decode_unit_pc_next_calc.sv
// Combinational next-PC: pc + 4, plus the sign-extended word offset of imm
// when the branch is taken. Wraps modulo 2^ADDR_W.
module pc_next_calc
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [IMM_W-1:0]  imm,
  input  logic              take_branch,
  output logic [ADDR_W-1:0] next_pc
);

  logic [ADDR_W-1:0] offset;

  // Sign-extend to 32 bits and scale to bytes before truncating to the PC width.
  assign offset  = take_branch ? ADDR_W'({{(32 - IMM_W - 2){imm[IMM_W-1]}}, imm, 2'b00})
                               : '0;
  assign next_pc = pc + ADDR_W'(PC_STEP) + offset;

endmodule

// File: rtl/fetch_decode_unit.sv
// Fetch/decode sequencer: owns the PC, fetches into the IR over a req/ack
// handshake and sequences PC update around memory-access stalls.
// Optional fetch watchdog enabled by defining FETCH_TIMEOUT_EN.
module fetch_decode_unit
  import cpu_pkg::*;
#(
  parameter int                ADDR_W      = 16,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter int                TIMEOUT_CYC = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  fetch_decode_unit_if.master       imem,
  input  logic                      pc_we,
  input  logic                      branch,
  input  logic                      branch_cond,
  input  logic                      mem_done,
  output logic [OP_MSB-OP_LSB:0]    op_code,
  output logic [FUNC_MSB-FUNC_LSB:0] func_code,
  output logic [RS_MSB-RS_LSB:0]    rs,
  output logic [RT_MSB-RT_LSB:0]    rt,
  output logic [RD_MSB-RD_LSB:0]    rd,
  output logic [IMM_W-1:0]          imm,
  output logic [ADDR_W-1:0]         pc,
  output logic                      instr_valid,
  output logic                      fetch_fault
);

  state_t             state, next_state;
  logic [INSTR_W-1:0] ir;
  logic [ADDR_W-1:0]  pc_q, next_pc;
  logic               req_q;
  logic               fetch_ok;
  logic               pc_update;
  logic               watchdog_trip;

  // The first S_FETCH cycle after reset has req low, so an ack there is ignored.
  assign fetch_ok = (state == S_FETCH) && req_q && imem.imem_ack;

  pc_next_calc #(.ADDR_W(ADDR_W)) u_pc_next (
    .pc          (pc_q),
    .imm         (ir[IMM_MSB:IMM_LSB]),
    .take_branch (branch & branch_cond),
    .next_pc     (next_pc)
  );

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] wd_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           wd_cnt <= '0;
    else if (state != S_FETCH)            wd_cnt <= '0;
    else if (req_q && !imem.imem_ack)     wd_cnt <= wd_cnt + CNT_W'(1);
  end

  // A same-cycle ack takes priority over the trip.
  assign watchdog_trip = (state == S_FETCH) && req_q && !imem.imem_ack &&
                         (wd_cnt == CNT_W'(TIMEOUT_CYC - 1));
  assign fetch_fault   = (state == S_FAULT);
`else
  assign watchdog_trip = 1'b0;
  assign fetch_fault   = 1'b0;
`endif

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case leaves it unassigned and infers a latch.
  always_comb begin
    next_state = state;
    pc_update  = 1'b0;
    unique case (state)
      S_FETCH: begin
        if (fetch_ok)           next_state = S_DECODE;
        else if (watchdog_trip) next_state = S_FAULT;
      end
      S_DECODE: begin
        if (pc_we) begin
          pc_update  = 1'b1;
          next_state = S_FETCH;
        end else begin
          next_state = S_MEM;
        end
      end
      S_MEM: begin
        if (mem_done) begin
          pc_update  = 1'b1;
          next_state = S_FETCH;
        end
      end
      S_FAULT: next_state = S_FAULT;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FETCH;
      req_q <= 1'b0;
      pc_q  <= RESET_PC;
      ir    <= '0;
    end else begin
      state <= next_state;
      req_q <= (next_state == S_FETCH);
      if (fetch_ok)  ir   <= imem.imem_rdata;
      if (pc_update) pc_q <= next_pc;
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc_q;

  assign op_code     = ir[OP_MSB:OP_LSB];
  assign func_code   = ir[FUNC_MSB:FUNC_LSB];
  assign rs          = ir[RS_MSB:RS_LSB];
  assign rt          = ir[RT_MSB:RT_LSB];
  assign rd          = ir[RD_MSB:RD_LSB];
  assign imm         = ir[IMM_MSB:IMM_LSB];
  assign pc          = pc_q;
  assign instr_valid = (state == S_DECODE);

endmodule

// File: doc/fetch_decode_unit.md
Name: fetch_decode_unit

Overview:
- Instruction fetch and decode sequencer that sits directly upstream of the control unit.
- Owns the PC, fetches 32-bit instruction words from instruction memory over a req/ack handshake, and latches them into an instruction register (IR).
- Drives op_code/func_code into the control unit and register/immediate fields to the datapath.
- Consumes the control unit's PC_WE and Branch, plus execute-stage status, to sequence PC update and memory-access stalls.

Parameters:
- ADDR_W, 16, PC / instruction-memory byte-address width.
- RESET_PC, 16'h0000, PC value loaded on reset.
- TIMEOUT_CYC, 64, fetch watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  fetch request, held high until imem_ack is sampled.
- imem_addr  out  ADDR_W  fetch address, equal to pc while imem_req is high.
- imem_ack  in  1  memory has valid data on imem_rdata this cycle.
- imem_rdata  in  32  instruction word.
- pc_we  in  1  from control unit PC_WE; 0 means a memory access is pending.
- branch  in  1  from control unit Branch.
- branch_cond  in  1  execute-stage condition (ALU zero).
- mem_done  in  1  data-memory access complete.
- op_code  out  6  IR[31:26] to the control unit.
- func_code  out  6  IR[5:0] to the control unit.
- rs, rt, rd  out  5 each  IR[25:21], IR[20:16], IR[15:11].
- imm  out  16  IR[15:0].
- pc  out  ADDR_W  address of the instruction currently held in IR.
- instr_valid  out  1  high exactly during S_DECODE.
- fetch_fault  out  1  sticky watchdog fault (optional feature only; tied 0 otherwise).

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-low; clock port clk, reset port rst_n.
- Reset values:
  - pc = RESET_PC.
  - IR = 0, so op_code, func_code and all fields read 0, which selects the control unit's NOP word.
  - imem_req = 0, instr_valid = 0, fetch_fault = 0.
  - state = S_FETCH; imem_req rises on the first clock edge after reset deasserts.
- States: S_FETCH, S_DECODE, S_MEM, plus S_FAULT with the optional feature.
- S_FETCH:
  - imem_req = 1, imem_addr = pc.
  - When imem_ack is sampled high: IR <= imem_rdata, imem_req <= 0, go to S_DECODE.
  - Zero-wait memory (ack in the first S_FETCH cycle) gives 2 cycles per non-memory instruction.
- S_DECODE:
  - instr_valid = 1 for exactly one cycle.
  - The control unit is combinational, so pc_we and branch are sampled in this same cycle.
  - pc_we = 1: PC update, go to S_FETCH.
  - pc_we = 0: go to S_MEM, pc held.
- S_MEM:
  - Hold IR and pc; instr_valid = 0.
  - When mem_done is sampled high: PC update, go to S_FETCH.
- PC update:
  - If (branch & branch_cond): pc <= pc + 4 + (sign_extend(imm) << 2).
  - Otherwise: pc <= pc + 4.
  - All arithmetic is truncated to ADDR_W, so wrap-around is modulo 2^ADDR_W with no error flag.
- IR and all field outputs stay stable from the IR load until the next imem_ack; they never change in S_DECODE or S_MEM.
- Ignored inputs:
  - imem_ack outside S_FETCH.
  - mem_done outside S_MEM.
  - branch and branch_cond outside the PC-update cycle.
- mem_done high in the same cycle S_MEM is entered is not seen; it is first sampled in the first cycle in S_MEM.
- Reset mid-operation (any state): immediate return to reset values; an in-flight fetch is abandoned and any late ack is ignored until the next S_FETCH.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to S_FETCH and increments each S_FETCH cycle without ack.
  - When it reaches TIMEOUT_CYC: go to S_FAULT, imem_req = 0, fetch_fault = 1.
  - S_FAULT is exited only by reset.
  - An ack arriving in the same cycle the count reaches TIMEOUT_CYC wins: normal load, no fault.
- Undefined: no counter and no S_FAULT; fetch_fault is tied 0; S_FETCH waits indefinitely.

Decomposition:
- Shared package cpu_pkg holds:
  - INSTR_W = 32.
  - Field bit positions (OP_MSB/LSB, FUNC_MSB/LSB, RS/RT/RD/IMM ranges).
  - State encoding constants S_FETCH/S_DECODE/S_MEM/S_FAULT.
  - PC_STEP = 4.
- Sub-module pc_next_calc: combinational next-PC computation (pc, imm, take_branch -> next_pc), reusable by a later pipelined fetch.

Test Plan:
- Reset release, zero-wait ack, imem_rdata = 32'h0000_0020 -> first imem_addr = 0; op_code = 0 and func_code = 6'h20 in S_DECODE; pc = 4 two cycles later.
- Ack delayed 3 cycles -> imem_req high for 4 cycles with imem_addr constant; instr_valid one cycle only; IR unchanged by spurious acks outside S_FETCH.
- pc = 16'h0010, branch = 1, branch_cond = 1, imm = 16'hFFFE -> next pc = 16'h000C; repeat with branch_cond = 0 -> 16'h0014.
- pc_we = 0 in S_DECODE, mem_done after 5 cycles -> no imem_req for 5 cycles; pc held; fetch of pc + 4 begins the cycle after mem_done.
- pc = 16'hFFFC, non-branch -> wraps to 16'h0000; rst_n pulsed low during S_MEM -> pc = RESET_PC, outputs 0 asynchronously.
- With FETCH_TIMEOUT_EN and TIMEOUT_CYC = 8, ack withheld -> fetch_fault = 1 after 8 S_FETCH cycles, imem_req = 0, fault persists until rst_n low.
